fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8: payload width per requester.
REQ-002 SHALL have parameter pBURST, default 4: maximum words per grant, range 1..255.
REQ-003 SHALL have parameter pTIMEOUT, default 16: idle cycles before a stalled grant is released, range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports s0_valid/s1_valid, input, 1 bit each: requester word available.
REQ-007 SHALL have ports s0_data/s1_data, input, pDATA_WIDTH each: requester payload.
REQ-008 SHALL have ports s0_last/s1_last, input, 1 bit each: final word of a requester packet.
REQ-009 SHALL have ports s0_ready/s1_ready, output, 1 bit each: word accepted when valid&&ready.
REQ-010 SHALL have port fifo_wen, output, 1 bit: write strobe to the downstream sync FIFO.
REQ-011 SHALL have port fifo_wdata, output, pDATA_WIDTH+1: {source id, payload}.
REQ-012 SHALL have port fifo_full, input, 1 bit: downstream FIFO full flag.
REQ-013 SHALL have port grant, output, 2 bits: one-hot current owner; 00 when idle.
REQ-014 SHALL have port timeout_flag, output, 1 bit: sticky, set on any timeout release.
REQ-015 SHALL have ports s0_count/s1_count, output, 16 bits each: words written per requester.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-017 SHALL, in IDLE with any valid, enter GRANTn next cycle; if both valid, pick the requester not served last (round-robin).
REQ-018 SHALL drive sN_ready = (state==GRANTn) && !fifo_full, combinationally.
REQ-019 SHALL drive fifo_wen = handshake of granted requester, same cycle; fifo_wdata = {n, sN_data}.
REQ-020 SHALL never assert fifo_wen while fifo_full is high.
REQ-021 SHALL count accepted words per grant (8-bit burst counter, cleared on grant entry).
REQ-022 SHALL release the grant on the handshake where sN_last=1 or burst count reaches pBURST.
REQ-023 SHALL, on release, in the next cycle enter the other GRANT state if the other valid is high, else re-enter the same GRANT if its valid is high, else IDLE; no idle bubble between grants.
REQ-024 SHALL hold the grant while the owner deasserts valid mid-packet (lock).
REQ-025 SHALL count consecutive cycles of owner valid low or fifo_full high; at pTIMEOUT release per REQ-023 and set timeout_flag.
REQ-026 SHALL reset the timeout counter on every handshake and on grant entry.
REQ-027 SHALL keep the non-granted requester's ready low at all times.
REQ-028 SHALL clear timeout_flag only by reset.

Reset
REQ-029 SHALL, on reset, force state IDLE, grant 00, both readys 0, fifo_wen 0, all counters 0, timeout_flag 0, round-robin so requester 0 wins first tie.
REQ-030 SHALL abort an in-progress burst on reset assertion with no further fifo_wen.
REQ-031 SHALL take first grant no earlier than the first clk edge after reset deasserts.

Configuration
REQ-032 SHALL, with macro FIFO_WRITE_ARBITER_STATS_EN defined, implement s0_count/s1_count as 16-bit counters of fifo_wen per source, saturating at 0xFFFF.
REQ-033 SHALL, without FIFO_WRITE_ARBITER_STATS_EN, tie s0_count/s1_count to 0 and synthesize no counter logic.

Verification
REQ-034 SHALL cover: both valid continuously, no last, pBURST=4 -> grant alternates every 4 writes, first grant s0, fifo_wdata MSB alternates 0/1.
REQ-035 SHALL cover: s1 sends 2-word packet (last on word 2) while s0 idle -> exactly 2 writes, grant 10 then 00.
REQ-036 SHALL cover: fifo_full held high 3 cycles mid-burst -> readys low, no fifo_wen, burst resumes, no word lost or duplicated.
REQ-037 SHALL cover: s0 granted then valid low 16 cycles, s1 valid -> grant moves to s1 on cycle 17, timeout_flag=1.
REQ-038 SHALL cover: reset asserted mid-burst -> fifo_wen low immediately, grant 00, counts 0; after release s0 wins first tie.
REQ-039 SHALL cover: STATS_EN defined, 70000 s0 writes -> s0_count=0xFFFF; undefined -> counts remain 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Two-requester write arbiter for a synchronous FIFO: round-robin, burst-limited, locked grants with stall timeout.
// Define FIFO_WRITE_ARBITER_STATS_EN to build the saturating per-source write counters.
module fifo_write_arbiter #(
    parameter int pDATA_WIDTH = 8,
    parameter int pBURST      = 4,
    parameter int pTIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s0_valid,
    input  logic [pDATA_WIDTH-1:0] s0_data,
    input  logic                   s0_last,
    output logic                   s0_ready,
    input  logic                   s1_valid,
    input  logic [pDATA_WIDTH-1:0] s1_data,
    input  logic                   s1_last,
    output logic                   s1_ready,
    output logic                   fifo_wen,
    output logic [pDATA_WIDTH:0]   fifo_wdata,
    input  logic                   fifo_full,
    output logic [1:0]             grant,
    output logic                   timeout_flag,
    output logic [15:0]            s0_count,
    output logic [15:0]            s1_count
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] burst_cnt;
    logic [7:0] tmo_cnt;
    logic       last_served;
    logic       owner_last;
    logic       handshake;
    logic       burst_done;
    logic       tmo_hit;
    logic       release_grant;

    always_comb begin
        s0_ready      = (state == GRANT0) && !fifo_full;
        s1_ready      = (state == GRANT1) && !fifo_full;
        owner_last    = (state == GRANT1) ? s1_last : s0_last;
        handshake     = (s0_ready && s0_valid) || (s1_ready && s1_valid);
        fifo_wen      = handshake;
        fifo_wdata    = (state == GRANT1) ? {1'b1, s1_data} : {1'b0, s0_data};
        grant         = {state == GRANT1, state == GRANT0};
        burst_done    = handshake && (owner_last || burst_cnt == 8'(pBURST - 1));
        // Stall cycles are exactly the granted cycles without a handshake
        tmo_hit       = (state != IDLE) && !handshake && tmo_cnt == 8'(pTIMEOUT - 1);
        release_grant = burst_done || tmo_hit;

        state_next = state;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) state_next = last_served ? GRANT0 : GRANT1;
                else if (s0_valid)        state_next = GRANT0;
                else if (s1_valid)        state_next = GRANT1;
            end
            GRANT0: if (release_grant) state_next = s1_valid ? GRANT1 : (s0_valid ? GRANT0 : IDLE);
            GRANT1: if (release_grant) state_next = s0_valid ? GRANT0 : (s1_valid ? GRANT1 : IDLE);
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_served  <= 1'b1;
            burst_cnt    <= '0;
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == GRANT0)      last_served <= 1'b0;
            else if (state_next == GRANT1) last_served <= 1'b1;
            // Every grant entry comes from IDLE or a release, so both clear the counters
            if (state == IDLE || release_grant) begin
                burst_cnt <= '0;
                tmo_cnt   <= '0;
            end else if (handshake) begin
                burst_cnt <= burst_cnt + 8'd1;
                tmo_cnt   <= '0;
            end else begin
                tmo_cnt   <= tmo_cnt + 8'd1;
            end
            if (tmo_hit) timeout_flag <= 1'b1;
        end
    end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (s0_ready && s0_valid && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (s1_ready && s1_valid && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign s0_count = cnt0;
    assign s1_count = cnt1;
`else
    assign s0_count = '0;
    assign s1_count = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, round-robin bursts, packet end, full stall, timeout, reset abort, stats.
module tb_fifo_write_arbiter;

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s0_valid = 1'b0;
    logic [7:0]  s0_data = 8'h00;
    logic        s0_last = 1'b0;
    logic        s0_ready;
    logic        s1_valid = 1'b0;
    logic [7:0]  s1_data = 8'h00;
    logic        s1_last = 1'b0;
    logic        s1_ready;
    logic        fifo_wen;
    logic [8:0]  fifo_wdata;
    logic        fifo_full = 1'b0;
    logic [1:0]  grant;
    logic        timeout_flag;
    logic [15:0] s0_count;
    logic [15:0] s1_count;

    int vectors = 0;
    int miscompares = 0;

    fifo_write_arbiter #(.pDATA_WIDTH(8), .pBURST(4), .pTIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .grant(grant), .timeout_flag(timeout_flag),
        .s0_count(s0_count), .s1_count(s1_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0; fifo_full = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        cyc();
        cyc();
        #1;
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant); end
        vectors++;
        if (fifo_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b want 0", fifo_wen); end
        vectors++;
        if ({s0_ready, s1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", {s0_ready, s1_ready}); end
        vectors++;
        if (timeout_flag !== 1'b0) begin miscompares++; $display("FAIL reset_tflag: got %b want 0", timeout_flag); end
        vectors++;
        if ({s0_count, s1_count} !== 32'h0) begin miscompares++; $display("FAIL reset_counts: got %h want 0", {s0_count, s1_count}); end
    endtask

    task automatic test_round_robin();
        logic       owner;
        logic [8:0] expd;
        do_reset();
        s0_data = 8'h3C; s1_data = 8'hC3;
        s0_valid = 1'b1; s1_valid = 1'b1;
        #1;
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL rr_first_edge: got %b want 00", grant); end
        for (int k = 0; k < 16; k++) begin
            cyc();
            #1;
            owner = ((k / 4) % 2) == 1;
            expd = owner ? 9'h1C3 : 9'h03C;
            vectors++;
            if (grant !== (owner ? 2'b10 : 2'b01)) begin
                miscompares++; $display("FAIL rr_grant k=%0d: got %b want %b", k, grant, owner ? 2'b10 : 2'b01);
            end
            vectors++;
            if (fifo_wen !== 1'b1 || fifo_wdata !== expd) begin
                miscompares++; $display("FAIL rr_write k=%0d: got wen=%b data=%h want wen=1 data=%h", k, fifo_wen, fifo_wdata, expd);
            end
            vectors++;
            if ((owner ? s0_ready : s1_ready) !== 1'b0) begin
                miscompares++; $display("FAIL rr_other_ready k=%0d: got 1 want 0", k);
            end
        end
    endtask

    task automatic test_packet();
        int writes;
        do_reset();
        s1_data = 8'h11; s1_valid = 1'b1;
        cyc();
        #1;
        vectors++;
        if (grant !== 2'b10 || fifo_wdata !== 9'h111) begin
            miscompares++; $display("FAIL pkt_word1: got grant=%b data=%h want 10/111", grant, fifo_wdata);
        end
        writes = fifo_wen ? 1 : 0;
        cyc();
        s1_data = 8'h22; s1_last = 1'b1;
        #1;
        vectors++;
        if (grant !== 2'b10 || fifo_wdata !== 9'h122) begin
            miscompares++; $display("FAIL pkt_word2: got grant=%b data=%h want 10/122", grant, fifo_wdata);
        end
        writes += fifo_wen ? 1 : 0;
        for (int k = 0; k < 24; k++) begin
            cyc();
            s1_valid = 1'b0; s1_last = 1'b0;
            #1;
            writes += fifo_wen ? 1 : 0;
        end
        vectors++;
        if (writes !== 2) begin miscompares++; $display("FAIL pkt_writes: got %0d want 2", writes); end
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL pkt_idle: got %b want 00", grant); end
    endtask

    task automatic test_full_stall();
        int         exp_wen[9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        int         full_pat[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        int         n = 0;
        logic       adv = 1'b0;
        logic [8:0] expd;
        do_reset();
        s0_data = 8'h10; s0_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            if (adv) s0_data = s0_data + 8'd1;
            fifo_full = (full_pat[k] != 0);
            #1;
            vectors++;
            if (fifo_wen !== (exp_wen[k] != 0)) begin
                miscompares++; $display("FAIL stall_wen k=%0d: got %b want %0d", k, fifo_wen, exp_wen[k]);
            end
            vectors++;
            if (s0_ready !== (full_pat[k] == 0)) begin
                miscompares++; $display("FAIL stall_ready k=%0d: got %b want %0d", k, s0_ready, full_pat[k] == 0);
            end
            if (exp_wen[k] != 0) begin
                expd = {1'b0, 8'h10 + 8'(n)};
                vectors++;
                if (fifo_wdata !== expd) begin
                    miscompares++; $display("FAIL stall_data k=%0d: got %h want %h", k, fifo_wdata, expd);
                end
                n++;
            end
            adv = s0_valid && s0_ready;
        end
        fifo_full = 1'b0;
        s0_valid = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        s0_data = 8'h55; s1_data = 8'h77;
        s0_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 1) begin s0_valid = 1'b0; s1_valid = 1'b1; end
            #1;
            vectors++;
            if (grant !== 2'b01 || fifo_wen !== 1'b0 || s1_ready !== 1'b0) begin
                miscompares++; $display("FAIL tmo_hold c=%0d: got grant=%b wen=%b r1=%b want 01/0/0", k, grant, fifo_wen, s1_ready);
            end
            vectors++;
            if (timeout_flag !== 1'b0) begin miscompares++; $display("FAIL tmo_early c=%0d: got 1 want 0", k); end
        end
        cyc();
        #1;
        vectors++;
        if (grant !== 2'b10 || fifo_wen !== 1'b1 || fifo_wdata !== 9'h177) begin
            miscompares++; $display("FAIL tmo_move: got grant=%b wen=%b data=%h want 10/1/177", grant, fifo_wen, fifo_wdata);
        end
        vectors++;
        if (timeout_flag !== 1'b1) begin miscompares++; $display("FAIL tmo_flag: got %b want 1", timeout_flag); end
        s1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        s0_data = 8'hA5; s1_data = 8'h5A;
        s0_valid = 1'b1; s1_valid = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        vectors++;
        if (fifo_wen !== 1'b0 || grant !== 2'b00 || s0_ready !== 1'b0) begin
            miscompares++; $display("FAIL abort_outputs: got wen=%b grant=%b r0=%b want 0/00/0", fifo_wen, grant, s0_ready);
        end
        vectors++;
        if ({s0_count, s1_count} !== 32'h0) begin miscompares++; $display("FAIL abort_counts: got %h want 0", {s0_count, s1_count}); end
        cyc();
        reset = 1'b0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL abort_idle: got %b want 00", grant); end
        cyc();
        #1;
        vectors++;
        if (grant !== 2'b01 || fifo_wdata !== 9'h0A5) begin
            miscompares++; $display("FAIL abort_tie: got grant=%b data=%h want 01/0a5", grant, fifo_wdata);
        end
    endtask

    task automatic test_stats();
        do_reset();
        s0_data = 8'h01; s0_valid = 1'b1;
        for (int k = 0; k < 101; k++) cyc();
        #1;
        vectors++;
        if (s0_count !== (STATS ? 16'd100 : 16'd0)) begin
            miscompares++; $display("FAIL stats_100: got %0d want %0d", s0_count, STATS ? 100 : 0);
        end
        for (int k = 0; k < 70000; k++) cyc();
        #1;
        vectors++;
        if (s0_count !== (STATS ? 16'hFFFF : 16'h0)) begin
            miscompares++; $display("FAIL stats_sat: got %h want %h", s0_count, STATS ? 16'hFFFF : 16'h0);
        end
        vectors++;
        if (s1_count !== 16'h0) begin miscompares++; $display("FAIL stats_s1: got %h want 0", s1_count); end
        s0_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet();
        test_full_stall();
        test_timeout();
        test_reset_mid_burst();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
